joker_ep_bridge: RTL and testbench
==================================

# joker_ep_bridge

Endpoint-side counterpart of the Joker TV command controller. It receives host command packets from the USB device core's EP2 OUT byte stream and presents them as a random-access buffer with the hasdata/len/addr/q/arm/arm_ack handshake. It also holds the controller's EP1 IN reply buffer, written through wren/addr/data/commit/commit_len, and streams each committed reply to the USB core.

## Interface
- `OUT_DEPTH`, 512: EP2 OUT buffer size in bytes (power of two, ≤1023).
- `IN_DEPTH`, 512: EP1 IN buffer size in bytes (power of two, ≤1024).
- `ACK_CYCLES`, 2: high time of arm_ack and commit_ack, in cycles (≥1).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high. Ports are `clk` and `reset`.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous active-high reset.
- `out_valid`  in  1  USB core OUT byte valid.
- `out_data`  in  8  OUT byte.
- `out_last`  in  1  last byte of the OUT packet.
- `out_ready`  out  1  bridge accepts the OUT byte.
- `buf_out_hasdata`  out  1  a complete command packet is held.
- `buf_out_len`  out  10  byte count of the held packet.
- `buf_out_addr`  in  11  controller read address.
- `buf_out_q`  out  8  byte at buf_out_addr, registered.
- `buf_out_arm`  in  1  controller releases the packet.
- `buf_out_arm_ack`  out  1  release acknowledge pulse.
- `usb_in_wren`  in  1  reply byte write enable.
- `usb_in_addr`  in  11  reply byte address.
- `usb_in_data`  in  8  reply byte.
- `usb_in_commit`  in  1  send request, level.
- `usb_in_commit_len`  in  11  reply length in bytes.
- `usb_in_ready`  out  1  IN buffer free for writing.
- `usb_in_commit_ack`  out  1  commit acknowledge pulse.
- `in_valid`  out  1  IN byte valid toward the USB core.
- `in_data`  out  8  IN byte.
- `in_last`  out  1  last beat of the IN packet.
- `in_zlp`  out  1  beat is a zero-length packet marker; in_data is don't-care.
- `in_ready`  in  1  USB core takes the beat.
- `out_overflow`  out  1  sticky: an OUT packet was truncated. Cleared only by reset.

## Operation
- Reset values:
  - `out_ready`=1, `usb_in_ready`=1.
  - `buf_out_hasdata`, `buf_out_arm_ack`, `usb_in_commit_ack`, `in_valid`, `in_last`, `in_zlp`, `out_overflow` = 0.
  - `buf_out_len`=0, `buf_out_q`=0, `in_data`=0.
  - OUT FSM in O_EMPTY, IN FSM in I_READY.
- OUT FSM:
  - O_EMPTY: the first accepted byte goes to O_FILL.
  - O_FILL: each accepted byte is written at the write pointer, then the pointer increments.
    - Bytes at index ≥ OUT_DEPTH are accepted and discarded, and set `out_overflow`.
    - `out_last` accepted: `buf_out_len` = min(count, OUT_DEPTH), `hasdata`=1, `out_ready`=0, go to O_FULL.
    - A one-byte packet (`out_valid` and `out_last` in O_EMPTY) goes straight to O_FULL with len=1.
  - O_FULL: on `buf_out_arm`=1, `hasdata`=0 and `arm_ack`=1 for ACK_CYCLES cycles, then `arm_ack`=0, go to O_DISARM.
  - O_DISARM: wait for `buf_out_arm`=0, then `out_ready`=1 and go to O_EMPTY.
  - `out_ready`=1 only in O_EMPTY and O_FILL. `buf_out_arm` outside O_FULL is ignored.
- OUT read port: `buf_out_q` = mem[`buf_out_addr` mod OUT_DEPTH], registered. It is valid regardless of FSM state.
- IN FSM:
  - I_READY: a `usb_in_wren` cycle writes mem[addr mod IN_DEPTH]. Writes in any other state are dropped.
    - On `usb_in_commit`=1: latch L = min(`commit_len`, IN_DEPTH), `usb_in_ready`=0, `commit_ack`=1 for ACK_CYCLES cycles, then go to I_SEND.
  - I_SEND: stream mem[0..L-1] to the USB core.
    - `in_last` is set on byte L-1.
    - L=0 sends one beat with `in_zlp`=1 and `in_last`=1.
    - After the last beat is taken, go to I_WAIT.
  - I_WAIT: when `usb_in_commit`=0, `usb_in_ready`=1 and go to I_READY.
- The OUT and IN FSMs are fully independent. Simultaneous events on the two sides never interact.
- `reset` asserted mid-packet or mid-stream: the in-flight packet is discarded and all outputs take their reset values.

## Timing
- `buf_out_q` latency: 1 cycle after `buf_out_addr`.
- `buf_out_hasdata` rises on the cycle after the `out_last` beat is accepted.
- `arm_ack` rises 1 cycle after `arm` is sampled high in O_FULL.
- `commit_ack` rises 1 cycle after `commit` is sampled high in I_READY.
- `in_valid` rises 2 cycles after `commit_ack` falls: 1 RAM read cycle plus 1 output register.
- IN stream: AXI-style valid/ready. `in_data`, `in_last` and `in_zlp` hold while `in_valid` && !`in_ready`. Sustained throughput is 1 byte/cycle, using a prefetch register.
- A write in the same cycle as commit is sampled is still accepted.
- `in_last` and `in_valid` fall on the cycle after the final handshake.

## Structure
- Package `joker_ep_pkg`:
  - OUT state encoding: O_EMPTY, O_FILL, O_FULL, O_ACK, O_DISARM.
  - IN state encoding: I_READY, I_ACK, I_SEND, I_WAIT.
  - Default depths and the ACK_CYCLES default.
- Sub-module `joker_ep_ram`: simple dual-port byte RAM (one write port, one registered read port), parameterised by depth. Instantiated twice.

## Test plan
- OUT packet 0x0B,0x34 with `out_last` on byte 2: `hasdata`=1, len=2; addr=1 gives q=0x34 next cycle. Arm: `arm_ack` high 2 cycles then low; after arm drops, `out_ready`=1.
- OUT packet of 600 bytes: len=512, `out_overflow`=1, q at addr 511 = byte 511. A second packet is not accepted until arm/disarm.
- IN write 0x0B@0, 0x5A@1, commit len=2: `commit_ack` pulses, stream 0x0B then 0x5A with `in_last` on 0x5A. `usb_in_ready` returns after commit drops.
- Commit len=0: a single beat with `in_zlp`=1 and `in_last`=1.
- Random `in_ready` stalls during a 512-byte reply: no byte lost or duplicated, data stable while stalled.
- Reset asserted mid-OUT fill and mid-IN stream: all outputs return to reset values; the next clean packet passes end-to-end.

Source files
------------

// File: rtl/joker_ep_pkg.sv
// rtl/joker_ep_pkg.sv - shared state encodings and defaults for the Joker endpoint bridge
// Purpose: OUT/IN FSM state types and default buffer depths / acknowledge width.
// Ports: none (package).
package joker_ep_pkg;

    typedef enum logic [2:0] {
        O_EMPTY,
        O_FILL,
        O_FULL,
        O_ACK,
        O_DISARM
    } out_state_t;

    typedef enum logic [1:0] {
        I_READY,
        I_ACK,
        I_SEND,
        I_WAIT
    } in_state_t;

    localparam int OUT_DEPTH_DEF  = 512;
    localparam int IN_DEPTH_DEF   = 512;
    localparam int ACK_CYCLES_DEF = 2;

endpackage

// File: rtl/joker_ep_ram.sv
// rtl/joker_ep_ram.sv - simple dual-port byte RAM with a registered read port
// Purpose: one write port, one read port whose output register resets to zero.
// Ports: clk, reset, we/waddr/wdata (write), raddr (read address), rdata (registered byte).
module joker_ep_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/joker_ep_bridge.sv
// rtl/joker_ep_bridge.sv - EP2 OUT command buffer and EP1 IN reply streamer for the Joker controller
// Purpose: captures OUT packets into a random-access buffer with hasdata/arm handshake;
//          streams committed IN replies with valid/ready at one byte per cycle.
// Ports: clk/reset; out_* (OUT byte stream in); buf_out_* (controller read side);
//        usb_in_* (controller reply write side); in_* (IN byte stream out); out_overflow.
module joker_ep_bridge
    import joker_ep_pkg::*;
#(
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
    parameter int IN_DEPTH   = IN_DEPTH_DEF,
    parameter int ACK_CYCLES = ACK_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_valid,
    input  logic [7:0]  out_data,
    input  logic        out_last,
    output logic        out_ready,
    output logic        buf_out_hasdata,
    output logic [9:0]  buf_out_len,
    input  logic [10:0] buf_out_addr,
    output logic [7:0]  buf_out_q,
    input  logic        buf_out_arm,
    output logic        buf_out_arm_ack,
    input  logic        usb_in_wren,
    input  logic [10:0] usb_in_addr,
    input  logic [7:0]  usb_in_data,
    input  logic        usb_in_commit,
    input  logic [10:0] usb_in_commit_len,
    output logic        usb_in_ready,
    output logic        usb_in_commit_ack,
    output logic        in_valid,
    output logic [7:0]  in_data,
    output logic        in_last,
    output logic        in_zlp,
    input  logic        in_ready,
    output logic        out_overflow
);

    localparam int          OAW      = $clog2(OUT_DEPTH);
    localparam int          IAW      = $clog2(IN_DEPTH);
    localparam logic [10:0] OUT_LIM  = 11'(OUT_DEPTH);
    localparam logic [10:0] IN_LIM   = 11'(IN_DEPTH);
    localparam logic [7:0]  ACK_LAST = 8'(ACK_CYCLES - 1);

    // ---------------- OUT side ----------------
    out_state_t  o_state_q, o_state_d;
    logic [10:0] wptr_q, wptr_d;      // saturates at OUT_DEPTH; excess bytes are dropped
    logic [9:0]  out_len_q, out_len_d;
    logic        hasdata_q, hasdata_d;
    logic        out_ready_q, out_ready_d;
    logic        arm_ack_q, arm_ack_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  o_cnt_q, o_cnt_d;
    logic        o_we;

    always_comb begin
        o_state_d   = o_state_q;
        wptr_d      = wptr_q;
        out_len_d   = out_len_q;
        hasdata_d   = hasdata_q;
        out_ready_d = out_ready_q;
        arm_ack_d   = arm_ack_q;
        overflow_d  = overflow_q;
        o_cnt_d     = o_cnt_q;
        o_we        = 1'b0;
        case (o_state_q)
            // O_EMPTY is O_FILL with the pointer at zero, so both share one path
            O_EMPTY, O_FILL: begin
                if (out_valid) begin
                    o_state_d = O_FILL;
                    if (wptr_q < OUT_LIM) begin
                        o_we   = 1'b1;
                        wptr_d = wptr_q + 11'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (out_last) begin
                        out_len_d   = (wptr_q < OUT_LIM) ? 10'(wptr_q + 11'd1) : 10'(OUT_LIM);
                        hasdata_d   = 1'b1;
                        out_ready_d = 1'b0;
                        o_state_d   = O_FULL;
                    end
                end
            end
            O_FULL: begin
                if (buf_out_arm) begin
                    hasdata_d = 1'b0;
                    arm_ack_d = 1'b1;
                    o_cnt_d   = 8'd0;
                    o_state_d = O_ACK;
                end
            end
            O_ACK: begin
                if (o_cnt_q == ACK_LAST) begin
                    arm_ack_d = 1'b0;
                    o_state_d = O_DISARM;
                end else begin
                    o_cnt_d = o_cnt_q + 8'd1;
                end
            end
            O_DISARM: begin
                if (!buf_out_arm) begin
                    out_ready_d = 1'b1;
                    wptr_d      = 11'd0;
                    o_state_d   = O_EMPTY;
                end
            end
            default: o_state_d = O_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_state_q   <= O_EMPTY;
            wptr_q      <= 11'd0;
            out_len_q   <= 10'd0;
            hasdata_q   <= 1'b0;
            out_ready_q <= 1'b1;
            arm_ack_q   <= 1'b0;
            overflow_q  <= 1'b0;
            o_cnt_q     <= 8'd0;
        end else begin
            o_state_q   <= o_state_d;
            wptr_q      <= wptr_d;
            out_len_q   <= out_len_d;
            hasdata_q   <= hasdata_d;
            out_ready_q <= out_ready_d;
            arm_ack_q   <= arm_ack_d;
            overflow_q  <= overflow_d;
            o_cnt_q     <= o_cnt_d;
        end
    end

    joker_ep_ram #(.DEPTH(OUT_DEPTH), .AW(OAW)) u_out_ram (
        .clk   (clk),
        .reset (reset),
        .we    (o_we),
        .waddr (wptr_q[OAW-1:0]),
        .wdata (out_data),
        .raddr (buf_out_addr[OAW-1:0]),
        .rdata (buf_out_q)
    );

    // ---------------- IN side ----------------
    in_state_t   i_state_q, i_state_d;
    logic [10:0] in_len_q, in_len_d;
    logic        in_rdy_q, in_rdy_d;
    logic        c_ack_q, c_ack_d;
    logic [7:0]  i_cnt_q, i_cnt_d;
    logic [10:0] rd_ptr_q, rd_ptr_d;      // next RAM address to fetch
    logic        rd_vld_q, rd_vld_d;      // RAM output register holds a fetched byte
    logic        rd_last_q, rd_last_d;
    logic        pf_vld_q, pf_vld_d;      // prefetch slot absorbs the byte in flight during a stall
    logic [7:0]  pf_data_q, pf_data_d;
    logic        pf_last_q, pf_last_d;
    logic        in_valid_q, in_valid_d;
    logic [7:0]  in_data_q, in_data_d;
    logic        in_last_q, in_last_d;
    logic        in_zlp_q, in_zlp_d;
    logic [10:0] fetch_lim;
    logic [7:0]  i_rdata;
    logic        i_we;

    // A zero-length reply still fetches one dummy byte so the marker beat has normal latency
    assign fetch_lim = (in_len_q == 11'd0) ? 11'd1 : in_len_q;
    assign i_we      = usb_in_wren && (i_state_q == I_READY);

    always_comb begin
        i_state_d  = i_state_q;
        in_len_d   = in_len_q;
        in_rdy_d   = in_rdy_q;
        c_ack_d    = c_ack_q;
        i_cnt_d    = i_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_vld_d   = 1'b0;
        rd_last_d  = rd_last_q;
        pf_vld_d   = pf_vld_q;
        pf_data_d  = pf_data_q;
        pf_last_d  = pf_last_q;
        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        in_last_d  = in_last_q;
        in_zlp_d   = in_zlp_q;
        case (i_state_q)
            I_READY: begin
                if (usb_in_commit) begin
                    in_len_d  = (usb_in_commit_len < IN_LIM) ? usb_in_commit_len : IN_LIM;
                    in_rdy_d  = 1'b0;
                    c_ack_d   = 1'b1;
                    i_cnt_d   = 8'd0;
                    i_state_d = I_ACK;
                end
            end
            I_ACK: begin
                if (i_cnt_q == ACK_LAST) begin
                    c_ack_d   = 1'b0;
                    i_state_d = I_SEND;
                end else begin
                    i_cnt_d = i_cnt_q + 8'd1;
                end
            end
            I_SEND: begin
                if (!in_valid_q || in_ready) begin
                    if (pf_vld_q) begin
                        in_valid_d = 1'b1;
                        in_data_d  = pf_data_q;
                        in_last_d  = pf_last_q;
                        in_zlp_d   = (in_len_q == 11'd0);
                        pf_vld_d   = rd_vld_q;
                        pf_data_d  = i_rdata;
                        pf_last_d  = rd_last_q;
                    end else if (rd_vld_q) begin
                        in_valid_d = 1'b1;
                        in_data_d  = i_rdata;
                        in_last_d  = rd_last_q;
                        in_zlp_d   = (in_len_q == 11'd0);
                    end else begin
                        in_valid_d = 1'b0;
                    end
                end else if (rd_vld_q) begin
                    pf_vld_d  = 1'b1;
                    pf_data_d = i_rdata;
                    pf_last_d = rd_last_q;
                end
                // Fetch only while the next byte is guaranteed a free slot on arrival
                if ((rd_ptr_q < fetch_lim) && !(in_valid_d && pf_vld_d)) begin
                    rd_ptr_d  = rd_ptr_q + 11'd1;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rd_ptr_q == fetch_lim - 11'd1);
                end
                if (in_valid_q && in_ready && in_last_q) begin
                    in_valid_d = 1'b0;
                    in_last_d  = 1'b0;
                    in_zlp_d   = 1'b0;
                    rd_ptr_d   = 11'd0;
                    rd_vld_d   = 1'b0;
                    pf_vld_d   = 1'b0;
                    i_state_d  = I_WAIT;
                end
            end
            I_WAIT: begin
                if (!usb_in_commit) begin
                    in_rdy_d  = 1'b1;
                    i_state_d = I_READY;
                end
            end
            default: i_state_d = I_READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_state_q  <= I_READY;
            in_len_q   <= 11'd0;
            in_rdy_q   <= 1'b1;
            c_ack_q    <= 1'b0;
            i_cnt_q    <= 8'd0;
            rd_ptr_q   <= 11'd0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            pf_vld_q   <= 1'b0;
            pf_data_q  <= 8'h00;
            pf_last_q  <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= 8'h00;
            in_last_q  <= 1'b0;
            in_zlp_q   <= 1'b0;
        end else begin
            i_state_q  <= i_state_d;
            in_len_q   <= in_len_d;
            in_rdy_q   <= in_rdy_d;
            c_ack_q    <= c_ack_d;
            i_cnt_q    <= i_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            pf_vld_q   <= pf_vld_d;
            pf_data_q  <= pf_data_d;
            pf_last_q  <= pf_last_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            in_last_q  <= in_last_d;
            in_zlp_q   <= in_zlp_d;
        end
    end

    joker_ep_ram #(.DEPTH(IN_DEPTH), .AW(IAW)) u_in_ram (
        .clk   (clk),
        .reset (reset),
        .we    (i_we),
        .waddr (usb_in_addr[IAW-1:0]),
        .wdata (usb_in_data),
        .raddr (rd_ptr_q[IAW-1:0]),
        .rdata (i_rdata)
    );

    // Address bits above the buffer size wrap by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^{buf_out_addr[10:OAW], usb_in_addr[10:IAW]};

    assign out_ready         = out_ready_q;
    assign buf_out_hasdata   = hasdata_q;
    assign buf_out_len       = out_len_q;
    assign buf_out_arm_ack   = arm_ack_q;
    assign out_overflow      = overflow_q;
    assign usb_in_ready      = in_rdy_q;
    assign usb_in_commit_ack = c_ack_q;
    assign in_valid          = in_valid_q;
    assign in_data           = in_data_q;
    assign in_last           = in_last_q;
    assign in_zlp            = in_zlp_q;

endmodule

// File: tb/tb_joker_ep_bridge.sv
// tb/tb_joker_ep_bridge.sv - directed self-checking bench for joker_ep_bridge
module tb_joker_ep_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_valid = 1'b0;
    logic [7:0]  out_data = 8'h00;
    logic        out_last = 1'b0;
    logic        out_ready;
    logic        buf_out_hasdata;
    logic [9:0]  buf_out_len;
    logic [10:0] buf_out_addr = 11'd0;
    logic [7:0]  buf_out_q;
    logic        buf_out_arm = 1'b0;
    logic        buf_out_arm_ack;
    logic        usb_in_wren = 1'b0;
    logic [10:0] usb_in_addr = 11'd0;
    logic [7:0]  usb_in_data = 8'h00;
    logic        usb_in_commit = 1'b0;
    logic [10:0] usb_in_commit_len = 11'd0;
    logic        usb_in_ready;
    logic        usb_in_commit_ack;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_zlp;
    logic        in_ready = 1'b0;
    logic        out_overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    joker_ep_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_ready         (out_ready),
        .buf_out_hasdata   (buf_out_hasdata),
        .buf_out_len       (buf_out_len),
        .buf_out_addr      (buf_out_addr),
        .buf_out_q         (buf_out_q),
        .buf_out_arm       (buf_out_arm),
        .buf_out_arm_ack   (buf_out_arm_ack),
        .usb_in_wren       (usb_in_wren),
        .usb_in_addr       (usb_in_addr),
        .usb_in_data       (usb_in_data),
        .usb_in_commit     (usb_in_commit),
        .usb_in_commit_len (usb_in_commit_len),
        .usb_in_ready      (usb_in_ready),
        .usb_in_commit_ack (usb_in_commit_ack),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_zlp            (in_zlp),
        .in_ready          (in_ready),
        .out_overflow      (out_overflow)
    );

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'((i * 7 + seed) ^ (i >> 8));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_ready", out_ready, 1);
        chk("rst_in_ready", usb_in_ready, 1);
        chk("rst_hasdata", buf_out_hasdata, 0);
        chk("rst_arm_ack", buf_out_arm_ack, 0);
        chk("rst_commit_ack", usb_in_commit_ack, 0);
        chk("rst_in_flags", {in_valid, in_last, in_zlp}, 0);
        chk("rst_overflow", out_overflow, 0);
        chk("rst_len", buf_out_len, 0);
        chk("rst_q", buf_out_q, 0);
        chk("rst_in_data", in_data, 0);
    endtask

    task automatic send_out(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            out_valid = 1'b1;
            out_data  = pat(i, seed);
            out_last  = (i == n - 1);
            tick();
        end
        out_valid = 1'b0;
        out_last  = 1'b0;
    endtask

    task automatic do_arm();
        buf_out_arm = 1'b1;
        tick();
        chk("arm_ack_1", {buf_out_arm_ack, buf_out_hasdata}, 2'b10);
        tick();
        chk("arm_ack_2", buf_out_arm_ack, 1);
        tick();
        chk("arm_ack_low", {buf_out_arm_ack, out_ready}, 2'b00);
        buf_out_arm = 1'b0;
        tick();
        chk("disarm_ready", out_ready, 1);
    endtask

    task automatic write_in(input int n, input int seed);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            usb_in_wren = 1'b1;
            usb_in_addr = 11'(i);
            usb_in_data = pat(i, seed);
            if (i < 512) exp_q.push_back(pat(i, seed));
            tick();
        end
        usb_in_wren = 1'b0;
    endtask

    // Called one sample after commit was taken; index 0 is that sample.
    task automatic run_in(input int n_exp, input bit zlp, input bit stall);
        int beats = 0;
        int ack_hi = 0;
        int first = -1;
        bit done = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [9:0] pb = 10'd0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (usb_in_commit_ack) ack_hi++;
            if (pv && !pr) chk("in_hold", {in_valid, in_data, in_last, in_zlp}, {1'b1, pb});
            in_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid && first < 0) first = c;
            if (in_valid && in_ready) begin
                if (zlp) begin
                    chk("zlp_beat", {in_last, in_zlp}, 2'b11);
                end else if (beats < n_exp) begin
                    chk("in_beat", {in_data, in_last, in_zlp}, {exp_q[beats], (beats == n_exp - 1), 1'b0});
                end else begin
                    chk("in_extra", beats, n_exp);
                end
                beats++;
                if (in_last) done = 1;
            end
            pv = in_valid;
            pr = in_ready;
            pb = {in_data, in_last, in_zlp};
            tick();
        end
        in_ready = 1'b0;
        chk("in_done", done, 1);
        chk("in_count", beats, zlp ? 1 : n_exp);
        chk("commit_ack_width", ack_hi, 2);
        chk("in_first_valid", first, 4);
        chk("in_after_last", {in_valid, in_last, in_zlp}, 0);
        chk("in_wait_busy", usb_in_ready, 0);
        usb_in_commit = 1'b0;
        tick();
        chk("in_ready_back", usb_in_ready, 1);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk_reset_vals();
        #3 reset = 1'b0;
        tick();

        // two-byte OUT packet 0x0B, 0x34
        out_valid = 1'b1; out_data = 8'h0B; out_last = 1'b0;
        tick();
        chk("fill_no_hasdata", {buf_out_hasdata, out_ready}, 2'b01);
        out_data = 8'h34; out_last = 1'b1;
        tick();
        out_valid = 1'b0; out_last = 1'b0;
        chk("pkt2_hasdata", {buf_out_hasdata, out_ready}, 2'b10);
        chk("pkt2_len", buf_out_len, 2);
        buf_out_addr = 11'd1;
        tick();
        chk("pkt2_q1", buf_out_q, 8'h34);
        buf_out_addr = 11'd0;
        tick();
        chk("pkt2_q0", buf_out_q, 8'h0B);
        do_arm();

        // 600-byte OUT packet truncates to 512
        send_out(600, 3);
        chk("big_hasdata", buf_out_hasdata, 1);
        chk("big_len", buf_out_len, 512);
        chk("big_overflow", out_overflow, 1);
        buf_out_addr = 11'd511;
        tick();
        chk("big_q511", buf_out_q, pat(511, 3));
        buf_out_addr = 11'd512 + 11'd5;
        tick();
        chk("big_q_wrap", buf_out_q, pat(5, 3));
        out_valid = 1'b1; out_data = 8'hEE; out_last = 1'b1;
        tick();
        tick();
        out_valid = 1'b0; out_last = 1'b0;
        chk("full_blocks", {out_ready, buf_out_len}, {1'b0, 10'd512});
        buf_out_addr = 11'd0;
        tick();
        chk("full_no_overwrite", buf_out_q, pat(0, 3));
        do_arm();
        chk("overflow_sticky", out_overflow, 1);

        // IN reply 0x0B, 0x5A; second write shares the commit cycle
        usb_in_wren = 1'b1; usb_in_addr = 11'd0; usb_in_data = 8'h0B;
        tick();
        usb_in_addr = 11'd1; usb_in_data = 8'h5A;
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd2;
        tick();
        usb_in_wren = 1'b0;
        chk("commit_state", {usb_in_commit_ack, usb_in_ready}, 2'b10);
        exp_q.delete();
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h5A);
        run_in(2, 1'b0, 1'b0);

        // zero-length reply
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd0;
        tick();
        run_in(0, 1'b1, 1'b0);

        // 512-byte reply with stalls; commit length above depth is clamped
        write_in(512, 11);
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd600;
        tick();
        run_in(512, 1'b0, 1'b1);

        // writes outside I_READY are dropped
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd1;
        usb_in_wren = 1'b1; usb_in_addr = 11'd0; usb_in_data = 8'hC3;
        tick();
        usb_in_data = 8'h99;
        exp_q.delete();
        exp_q.push_back(8'hC3);
        run_in(1, 1'b0, 1'b0);
        usb_in_wren = 1'b0;

        // reset mid-OUT fill and mid-IN stream
        write_in(4, 21);
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd4;
        for (int i = 0; i < 8; i++) begin
            out_valid = 1'b1; out_data = pat(i, 40); out_last = 1'b0;
            tick();
        end
        chk("pre_reset_busy", {in_valid, buf_out_hasdata, usb_in_ready}, 3'b100);
        out_valid = 1'b0;
        usb_in_commit = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_reset_vals();
        tick();
        #3 reset = 1'b0;
        tick();

        // clean traffic after reset
        send_out(3, 50);
        chk("clean_out", {buf_out_hasdata, buf_out_len}, {1'b1, 10'd3});
        buf_out_addr = 11'd2;
        tick();
        chk("clean_q2", buf_out_q, pat(2, 50));
        do_arm();
        write_in(3, 60);
        usb_in_commit = 1'b1; usb_in_commit_len = 11'd3;
        tick();
        run_in(3, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
